// File: rtl/branch_target_unit_if.sv
// Request/response bundle for branch_target_unit: request side, flush,
// result side and the delivered-taken counter.
interface branch_target_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_link;
    logic            out_misalign;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output in_valid, op, pc, imm, rs1_val, rs2_val, flush, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link, out_misalign, taken_count
    );

    modport slave (
        input  in_valid, op, pc, imm, rs1_val, rs2_val, flush, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_link, out_misalign, taken_count
    );
endinterface

// File: rtl/branch_target_unit.sv
// Branch/jump resolve unit: one-deep output register, latency 1, full throughput.
// Optional BTU_MISALIGN_EN adds a registered misaligned-target flag.
module branch_target_unit #(
    parameter int XLEN      = 32,
    parameter int IMM_SHIFT = 1,
    parameter int CNT_W     = 16
) (
    input logic             clk,
    input logic             rst_n,
    branch_target_unit_if.slave bus
);
    typedef enum logic [3:0] {
        OP_BEQ  = 4'd0,
        OP_BNE  = 4'd1,
        OP_BLT  = 4'd4,
        OP_BGE  = 4'd5,
        OP_BLTU = 4'd6,
        OP_BGEU = 4'd7,
        OP_JAL  = 4'd8,
        OP_JALR = 4'd9
    } op_e;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
    } resp_t;

    resp_t            resp_d, resp_q;
    logic             valid_q;
    logic             accept;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  jalr_sum;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
    assign br_target    = bus.pc + (bus.imm << IMM_SHIFT);
    assign jalr_sum     = bus.rs1_val + bus.imm;

    always_comb begin
        resp_d        = '0;
        resp_d.link   = bus.pc + XLEN'(4);
        resp_d.target = resp_d.link;
        case (bus.op)
            OP_BEQ:           resp_d.taken = (bus.rs1_val == bus.rs2_val);
            OP_BNE:           resp_d.taken = (bus.rs1_val != bus.rs2_val);
            OP_BLT:           resp_d.taken = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
            OP_BGE:           resp_d.taken = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
            OP_BLTU:          resp_d.taken = (bus.rs1_val <  bus.rs2_val);
            OP_BGEU:          resp_d.taken = (bus.rs1_val >= bus.rs2_val);
            OP_JAL, OP_JALR:  resp_d.taken = 1'b1;
            default:          resp_d.taken = 1'b0;
        endcase
        if (resp_d.taken)
            resp_d.target = (bus.op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
    end

    // Flush wins over both consumption and capture; a same-cycle consume+accept just overwrites.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            resp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (bus.flush)
                valid_q <= 1'b0;
            else if (accept) begin
                valid_q <= 1'b1;
                resp_q  <= resp_d;
            end else if (bus.out_ready)
                valid_q <= 1'b0;

            if (valid_q && bus.out_ready && resp_q.taken && !bus.flush && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef BTU_MISALIGN_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (!bus.flush && accept)
            misalign_q <= resp_d.taken && (resp_d.target[1:0] != 2'b00);
    end

    assign bus.out_misalign = misalign_q;
`else
    assign bus.out_misalign = 1'b0;
`endif

    assign bus.out_valid   = valid_q;
    assign bus.out_taken   = resp_q.taken;
    assign bus.out_target  = resp_q.target;
    assign bus.out_link    = resp_q.link;
    assign bus.taken_count = cnt_q;
endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: directed cases, stall, flush, random traffic
// against a queue-based reference, and counter saturation on a CNT_W=2 copy.
module tb_branch_target_unit;
    localparam int XLEN = 32;
`ifdef BTU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_target_unit_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
    branch_target_unit_if #(.XLEN(XLEN), .CNT_W(2))  bus2 ();

    branch_target_unit #(.XLEN(XLEN), .IMM_SHIFT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    branch_target_unit #(.XLEN(XLEN), .IMM_SHIFT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int unsigned m_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic        rdy_seen, rdy_exp;

    // Architectural rules written directly: compare, then pick target.
    function automatic exp_t ref_result(input logic [3:0] o, input logic [31:0] p, im, a, b);
        exp_t e;
        logic tk;
        logic [31:0] t;
        case (o)
            4'd0: tk = (a == b);
            4'd1: tk = (a != b);
            4'd4: tk = ($signed(a) < $signed(b));
            4'd5: tk = ($signed(a) >= $signed(b));
            4'd6: tk = (a < b);
            4'd7: tk = (a >= b);
            4'd8, 4'd9: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        e.link  = p + 32'd4;
        e.taken = tk;
        if (!tk)          t = e.link;
        else if (o == 9)  t = (a + im) & 32'hFFFF_FFFE;
        else              t = p + (im * 2);
        e.target = t;
        e.mis    = MIS_EN && tk && (t % 4 != 0);
        return e;
    endfunction

    function automatic logic [66:0] exp_vec();
        if (q.size() == 0) return '0;
        return {1'b1, q[0].taken, q[0].target, q[0].link, q[0].mis};
    endfunction

    function automatic logic [66:0] obs_vec();
        if (bus.out_valid !== 1'b1) return {bus.out_valid, 66'b0};
        return {bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.out_misalign};
    endfunction

    // Drive one cycle at negedge, advance the reference at posedge, return at next negedge.
    task automatic step(input logic v, input logic [3:0] o, input logic [31:0] p, im, a, b,
                        input logic fl, input logic rdy);
        bus.in_valid = v; bus.op = o; bus.pc = p; bus.imm = im;
        bus.rs1_val = a; bus.rs2_val = b; bus.flush = fl; bus.out_ready = rdy;
        #1;
        rdy_seen = bus.in_ready;
        rdy_exp  = (q.size() == 0) || rdy;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && rdy) begin
                if (q[0].taken && m_cnt < 65535) m_cnt++;
                void'(q.pop_front());
            end
            if (v && rdy_exp) q.push_back(ref_result(o, p, im, a, b));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1; bus.op = 4'd8; bus.pc = 32'h40; bus.imm = 32'h8;
        bus.rs1_val = 0; bus.rs2_val = 0; bus.flush = 0; bus.out_ready = 0;
        bus2.in_valid = 0; bus2.op = 0; bus2.pc = 0; bus2.imm = 0;
        bus2.rs1_val = 0; bus2.rs2_val = 0; bus2.flush = 0; bus2.out_ready = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.out_misalign, bus.taken_count} !== '0)
            begin errors++; $display("FAIL reset_outputs: got v=%b t=%b tgt=%h lnk=%h mis=%b cnt=%0d, want all 0",
                bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.out_misalign, bus.taken_count); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        bus.in_valid = 0;
        rst_n = 1;
        q.delete(); m_cnt = 0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL post_reset: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_directed();
        logic [65:0] want;
        step(1, 4'd0, 32'h100, 32'h10, 32'd5, 32'd5, 0, 1);
        checks++;
        if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link} !== {2'b11, 32'h120, 32'h104})
            begin errors++; $display("FAIL beq_taken: got v=%b t=%b tgt=%h lnk=%h want 1 1 120 104",
                bus.out_valid, bus.out_taken, bus.out_target, bus.out_link); end
        step(1, 4'd4, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'd1, 0, 1);
        checks++;
        if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link} !== {2'b11, 32'h210, 32'h204})
            begin errors++; $display("FAIL blt_signed: got t=%b tgt=%h want 1 210", bus.out_taken, bus.out_target); end
        step(1, 4'd6, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'd1, 0, 1);
        checks++;
        if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link} !== {2'b10, 32'h204, 32'h204})
            begin errors++; $display("FAIL bltu_not_taken: got t=%b tgt=%h want 0 204", bus.out_taken, bus.out_target); end
        step(1, 4'd9, 32'h300, 32'h0, 32'h1003, 32'd0, 0, 1);
        checks++;
        if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.out_misalign} !== {2'b11, 32'h1002, 32'h304, MIS_EN})
            begin errors++; $display("FAIL jalr_target: got tgt=%h mis=%b want 1002 %b", bus.out_target, bus.out_misalign, MIS_EN); end
        step(1, 4'd8, 32'hFFFF_FFFC, 32'h4, 32'd0, 32'd0, 0, 1);
        want = {2'b11, 32'h4, 32'h0};
        checks++;
        if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link} !== want)
            begin errors++; $display("FAIL jal_wrap: got tgt=%h lnk=%h want 00000004 00000000", bus.out_target, bus.out_link); end
        step(0, 4'd0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.taken_count !== 16'(m_cnt))
            begin errors++; $display("FAIL directed_drain: v=%b cnt=%0d want 0 %0d", bus.out_valid, bus.taken_count, m_cnt); end
    endtask

    task automatic test_back_to_back();
        step(1, 4'd1, 32'h500, 32'h20, 32'd1, 32'd2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'd8, 32'h600, 32'h40, 0, 0, 0, 0);
            checks++;
            if (rdy_seen !== 1'b0 || obs_vec() !== exp_vec())
                begin errors++; $display("FAIL stall_hold[%0d]: in_ready=%b out=%h want 0 %h", i, rdy_seen, obs_vec(), exp_vec()); end
        end
        step(1, 4'd8, 32'h600, 32'h40, 0, 0, 0, 1);
        checks++;
        if (rdy_seen !== 1'b1 || obs_vec() !== exp_vec() || bus.out_target !== 32'h680)
            begin errors++; $display("FAIL b2b_replace: in_ready=%b tgt=%h want 1 680", rdy_seen, bus.out_target); end
        step(0, 4'd0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.taken_count !== 16'(m_cnt))
            begin errors++; $display("FAIL b2b_drain: v=%b cnt=%0d want 0 %0d", bus.out_valid, bus.taken_count, m_cnt); end
    endtask

    task automatic test_flush();
        int unsigned c0;
        step(1, 4'd8, 32'h700, 32'h10, 0, 0, 0, 0);
        c0 = m_cnt;
        step(1, 4'd0, 32'h800, 32'h10, 32'd3, 32'd3, 1, 1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.taken_count !== 16'(c0))
            begin errors++; $display("FAIL flush_drop: v=%b cnt=%0d want 0 %0d", bus.out_valid, bus.taken_count, c0); end
        step(1, 4'd9, 32'h900, 32'h4, 32'h2000, 0, 0, 1);
        checks++;
        if (obs_vec() !== exp_vec() || bus.out_target !== 32'h2004)
            begin errors++; $display("FAIL flush_recover: out=%h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd14};
        logic [31:0] a, b;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 9)], $urandom, $urandom, a, b,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            checks++;
            if (rdy_seen !== rdy_exp || obs_vec() !== exp_vec() || bus.taken_count !== 16'(m_cnt))
                begin errors++; $display("FAIL random[%0d]: in_ready=%b out=%h cnt=%0d want %b %h %0d",
                    i, rdy_seen, obs_vec(), bus.taken_count, rdy_exp, exp_vec(), m_cnt); end
        end
    endtask

    task automatic test_saturate();
        int sent = 0;
        bus2.op = 4'd8; bus2.pc = 32'h1000; bus2.imm = 32'h10; bus2.out_ready = 1; bus2.flush = 0;
        bus2.in_valid = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus2.taken_count !== 2'd2)
            begin errors++; $display("FAIL sat_partial: cnt=%0d want 2", bus2.taken_count); end
        repeat (2) @(negedge clk);
        bus2.in_valid = 0;
        sent = 5;
        repeat (3) @(negedge clk);
        checks++;
        if (int'(bus2.taken_count) !== ((sent > 3) ? 3 : sent))
            begin errors++; $display("FAIL sat_count: cnt=%0d want 3", bus2.taken_count); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width in bits (legal 32 or 64).
REQ-002 SHALL have parameter IMM_SHIFT, default 1: left-shift applied to branch/JAL immediates.
REQ-003 SHALL have parameter CNT_W, default 16: width of taken_count.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 op  input  4  operation: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU, 8 JAL, 9 JALR; others reserved.
REQ-009 pc  input  XLEN  address of the control-transfer instruction.
REQ-010 imm  input  XLEN  sign-extended immediate, unshifted.
REQ-011 rs1_val, rs2_val  input  XLEN each  source operands.
REQ-012 flush  input  1  discard held and incoming requests.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_taken  output  1  control transfer taken.
REQ-016 out_target  output  XLEN  next PC.
REQ-017 out_link  output  XLEN  pc+4 (return address).
REQ-018 out_misalign  output  1  taken target not 4-byte aligned.
REQ-019 taken_count  output  CNT_W  saturating count of delivered taken results.

Function
REQ-020 SHALL hold one result in an output register; in_ready = !out_valid || out_ready, combinational.
REQ-021 SHALL accept a request on in_valid && in_ready && !flush; result appears at out_valid the next cycle (latency 1, throughput 1/cycle).
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL compare BEQ/BNE for equality, BLT/BGE signed, BLTU/BGEU unsigned, over full XLEN.
REQ-024 SHALL compute taken branch and JAL targets as pc + (imm << IMM_SHIFT), truncated modulo 2^XLEN (wrap-around, no overflow flag).
REQ-025 SHALL compute JALR target as (rs1_val + imm) with bit 0 cleared, modulo 2^XLEN; JAL and JALR always taken.
REQ-026 SHALL, for not-taken branches and reserved ops, drive out_taken=0 and out_target=out_link=pc+4 modulo 2^XLEN.
REQ-027 SHALL, on flush, clear out_valid next cycle and not capture that cycle's request, regardless of in_valid/out_ready.
REQ-028 SHALL increment taken_count on out_valid && out_ready && out_taken && !flush; saturate at 2^CNT_W-1.
REQ-029 SHALL, when a new request is accepted in the same cycle the held result is consumed, replace it without a bubble.

Reset
REQ-030 SHALL, while rst_n low at a clk edge, set out_valid=0, out_taken=0, out_target=0, out_link=0, out_misalign=0, taken_count=0.
REQ-031 SHALL drop any held or in-flight request on reset; in_ready=1 in the first cycle after reset release.

Configuration
REQ-032 SHALL use macro BTU_MISALIGN_EN: defined -> out_misalign = out_taken && out_target[1:0]!=0, registered with the result; undefined -> out_misalign tied 0, no check logic.

Verification
REQ-033 BEQ pc=0x100, imm=0x10, rs1=rs2=5 -> next cycle out_valid=1, out_taken=1, out_target=0x120, out_link=0x104.
REQ-034 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, out_target=pc+4.
REQ-035 JALR rs1=0x1003, imm=0 -> out_target=0x1002; with BTU_MISALIGN_EN out_misalign=1, without 0.
REQ-036 JAL pc=0xFFFFFFFC, imm=4 -> out_target=0x00000004 (wrap).
REQ-037 out_ready=0 for 3 cycles with second request pending -> in_ready=0, out_* stable; then out_ready=1 -> back-to-back delivery, no loss.
REQ-038 flush asserted with held taken result and out_ready=1 -> out_valid=0 next cycle, taken_count unchanged; CNT_W=2, 5 taken deliveries -> taken_count=3.
